// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M multiply/divide encodings and sequencer states
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;
  localparam logic [6:0] OP_OPCODE = 7'b0110011;

  function automatic logic md_is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between execute stage and muldiv_seq
interface muldiv_if #(
  parameter int DWIDTH = 32
);
  logic              start_i;
  logic [2:0]        funct3_i;
  logic [DWIDTH-1:0] rs1_i;
  logic [DWIDTH-1:0] rs2_i;
  logic              kill_i;
  logic              busy_o;
  logic              stall_o;
  logic              done_o;
  logic [DWIDTH-1:0] res_o;

  modport master (
    output start_i, funct3_i, rs1_i, rs2_i, kill_i,
    input  busy_o, stall_o, done_o, res_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_i, rs2_i, kill_i,
    output busy_o, stall_o, done_o, res_o
  );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step #(
  parameter int DWIDTH = 32
) (
  input  logic [2*DWIDTH-1:0] acc_i,
  input  logic [DWIDTH-1:0]   opnd_i,
  input  logic                div_i,
  output logic [2*DWIDTH-1:0] acc_o,
  output logic                qbit_o
);
  logic [DWIDTH:0]   add_sum;
  logic [DWIDTH:0]   rem_shift;
  logic [DWIDTH-1:0] rem_diff;

  // Divide mode leaves acc_o[0] clear; the caller merges qbit_o into it.
  always_comb begin
    add_sum   = {1'b0, acc_i[2*DWIDTH-1:DWIDTH]}
              + (acc_i[0] ? {1'b0, opnd_i} : {(DWIDTH+1){1'b0}});
    rem_shift = acc_i[2*DWIDTH-1:DWIDTH-1];
    rem_diff  = rem_shift[DWIDTH-1:0] - opnd_i;
    qbit_o    = 1'b0;
    acc_o     = {add_sum, acc_i[DWIDTH-1:1]};
    if (div_i) begin
      qbit_o = (rem_shift >= {1'b0, opnd_i});
      acc_o  = {(qbit_o ? rem_diff : rem_shift[DWIDTH-1:0]), acc_i[DWIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply/divide sequencer with pipeline stall
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave md
);
  localparam int            CW   = $clog2(DWIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] SMIN = {1'b1, {(DWIDTH-1){1'b0}}};

  muldiv_state_e       state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [DWIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [DWIDTH-1:0]   opnd_q, opnd_d, res_q, res_d;
  logic [2*DWIDTH-1:0] acc_q, acc_d;
  logic                neg_q, neg_d, rsign_q, rsign_d, done_q, done_d;

  logic [2*DWIDTH-1:0] step_acc, prod;
  logic                step_q, is_div, sign_a, sign_b, div_zero, div_ovf;
  logic [DWIDTH-1:0]   mag_a, mag_b, quo, rem;

  muldiv_step #(.DWIDTH(DWIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div),
    .acc_o  (step_acc),
    .qbit_o (step_q)
  );

  // An unsigned DWIDTH-bit magnitude already holds 2^(DWIDTH-1).
  always_comb begin
    is_div   = md_is_div(f3_q);
    sign_a   = a_q[DWIDTH-1] & (f3_q == MD_MULH || f3_q == MD_MULHSU ||
                                f3_q == MD_DIV  || f3_q == MD_REM);
    sign_b   = b_q[DWIDTH-1] & (f3_q == MD_MULH || f3_q == MD_DIV || f3_q == MD_REM);
    mag_a    = sign_a ? -a_q : a_q;
    mag_b    = sign_b ? -b_q : b_q;
    div_zero = is_div & (b_q == '0);
    div_ovf  = (f3_q == MD_DIV || f3_q == MD_REM) & (a_q == SMIN) & (b_q == '1);
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
    rem      = rsign_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rsign_d = rsign_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start_i && !md.kill_i) begin
          f3_d    = md.funct3_i;
          a_d     = md.rs1_i;
          b_d     = md.rs2_i;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        cnt_d   = '0;
        neg_d   = sign_a ^ sign_b;
        rsign_d = sign_a;
        opnd_d  = is_div ? mag_b : mag_a;
        acc_d   = {{DWIDTH{1'b0}}, (is_div ? mag_b : mag_a) ^ mag_a ^ mag_b};
        if (md.kill_i) begin
          state_d = ST_IDLE;
        end else if (div_zero) begin
          res_d   = f3_q[1] ? a_q : '1;
          state_d = ST_DONE;
        end else if (div_ovf) begin
          res_d   = f3_q[1] ? '0 : a_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (md.kill_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc | {{(2*DWIDTH-1){1'b0}}, step_q};
          if (cnt_q == LAST) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FIX: begin
        if (md.kill_i) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div) begin
            res_d = f3_q[1] ? rem : quo;
          end else begin
            res_d = (f3_q == MD_MUL) ? prod[DWIDTH-1:0] : prod[2*DWIDTH-1:DWIDTH];
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rsign_q <= rsign_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign md.busy_o  = (state_q != ST_IDLE);
  assign md.stall_o = (md.start_i && state_q == ST_IDLE) ||
                      (state_q != ST_IDLE && state_q != ST_DONE);
  assign md.done_o  = done_q;
  assign md.res_o   = res_q;

endmodule
